fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   Instruction-fetch stage of the 5-stage pipeline: owns the PC register, the
//   next-PC select and the fetch/decode latch. Consumes hazard_unit controls
//   (PC_WEN, fd_state, PCSrc) and drives the icache request plus decode inputs.
//   Holds a redirect (branch/jump) that resolves while the PC is frozen and
//   applies it on the next PC write, squashing the wrong-path fetch.
// PARAMETERS
//   PC_INIT   32'h0000_0000   PC value loaded on reset
// PORTS
//   CLK            in   1    clock, all state updates on rising edge
//   nRST           in   1    reset, asynchronous, active-low
//   ihit           in   1    icache returns imemload for imemaddr this cycle
//   imemload       in   32   instruction word from icache
//   PC_WEN         in   1    PC write enable from hazard_unit
//   fd_state       in   2    pipestate_t (cpu_types_pkg): PIPE_ENABLE/STALL/NOP
//   PCSrc          in   2    0 PC+4, 1 branch_target, 2 jump_target, 3 jr_target
//   branch_target  in   32   resolved branch address (mem stage)
//   jump_target    in   32   J/JAL address {pc[31:28],imm26,2'b00}
//   jr_target      in   32   JR register value
//   halt_in        in   1    decode has HALT in d_instr
//   imemREN        out  1    icache read enable
//   imemaddr       out  32   fetch address (= PC)
//   d_instr        out  32   latched instruction to decode
//   d_pcplus4      out  32   latched PC+4 of d_instr
//   d_valid        out  1    d_instr is a real (non-bubble) instruction
//   fetch_halted   out  1    fetch stopped after HALT
// BEHAVIOUR
//   Reset (nRST=0, async): PC=PC_INIT, state=FETCH, pend=0, d_instr=0,
//     d_pcplus4=0, d_valid=0; outputs imemaddr=PC_INIT, imemREN=1,
//     fetch_halted=0. Reset mid-redirect discards pend.
//   Combinational: imemaddr=PC; imemREN=(state!=HALTED); fetch_halted=(state==HALTED);
//     tgt = PCSrc mux of {PC+4, branch_target, jump_target, jr_target}, bits[1:0]
//     forced to 2'b00. PC+4 is mod 2^32 (32'hFFFF_FFFC -> 0).
//   FSM states FETCH, REDIRECT_WAIT, HALTED:
//   FETCH:
//     PC_WEN=1            : PC<=tgt (PCSrc 0 gives PC+4), stay FETCH.
//     PC_WEN=0, PCSrc!=0  : pend<=tgt, PC held, -> REDIRECT_WAIT.
//     PC_WEN=0, PCSrc==0  : hold.
//     halt_in & d_valid & PCSrc==0 : -> HALTED, PC held (halt beats PC_WEN).
//     halt_in with PCSrc!=0: redirect wins; HALT is wrong-path, no halt.
//   REDIRECT_WAIT:
//     PCSrc!=0 each cycle reloads pend<=tgt (youngest resolved redirect wins).
//     PC_WEN=1 : PC<=pend (not tgt), fd latch forced to bubble regardless of
//                fd_state, -> FETCH.
//     halt_in ignored in this state.
//   HALTED: PC, latch, pend frozen; imemREN=0; exit only by reset.
//   Fetch/decode latch (one register stage, 1-cycle latency fetch->decode):
//     PIPE_ENABLE : d_instr<=imemload, d_pcplus4<=PC+4, d_valid<=1
//     PIPE_STALL  : hold all three
//     PIPE_NOP    : d_instr<=0, d_pcplus4<=0, d_valid<=0
//     Squash (REDIRECT_WAIT exit) overrides ENABLE/STALL with NOP values.
//     In HALTED the latch holds regardless of fd_state.
//   Invalid fd_state encoding behaves as PIPE_STALL.
// TESTING
//   Reset, ihit=1, PC_WEN=1, fd_state=ENABLE, PCSrc=0, 3 cycles -> imemaddr
//     0,4,8,C; d_pcplus4 4,8,C one cycle after each fetch; d_valid=1.
//   PCSrc=1, branch_target=32'h0000_0103, PC_WEN=1, fd_state=NOP -> next
//     imemaddr=32'h100, d_valid=0.
//   PCSrc=2 jump_target=32'h40 with PC_WEN=0 for 3 cycles, then PC_WEN=1,
//     fd_state=ENABLE -> imemaddr stays old PC, then 32'h40; d_valid=0 after.
//   PC=32'hFFFF_FFFC, PCSrc=0, PC_WEN=1 -> imemaddr=0.
//   d_valid=1, halt_in=1, PCSrc=0 -> next cycle imemREN=0, fetch_halted=1, PC
//     frozen 10 cycles despite PC_WEN=1; same with PCSrc=3 -> no halt, PC=jr_target.
//   nRST low during REDIRECT_WAIT -> imemaddr=PC_INIT, pend not applied after.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: icache request/response, hazard-unit controls and the
// fetch/decode latch outputs seen by the decode stage.
interface fetch_stage_if;
    logic        ihit;
    logic [31:0] imemload;
    logic        PC_WEN;
    logic [1:0]  fd_state;
    logic [1:0]  PCSrc;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] jr_target;
    logic        halt_in;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic [31:0] d_instr;
    logic [31:0] d_pcplus4;
    logic        d_valid;
    logic        fetch_halted;

    // Seen from the fetch stage itself.
    modport master (
        input  ihit, imemload, PC_WEN, fd_state, PCSrc,
        input  branch_target, jump_target, jr_target, halt_in,
        output imemREN, imemaddr, d_instr, d_pcplus4, d_valid, fetch_halted
    );

    // Seen from the surrounding pipeline / icache.
    modport slave (
        output ihit, imemload, PC_WEN, fd_state, PCSrc,
        output branch_target, jump_target, jr_target, halt_in,
        input  imemREN, imemaddr, d_instr, d_pcplus4, d_valid, fetch_halted
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC select, deferred redirect
// while the PC is frozen, HALT detection and the fetch/decode latch.
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic          CLK,
    input  logic          nRST,
    fetch_stage_if.master fif
);
    localparam logic [1:0] PIPE_ENABLE = 2'd0;
    localparam logic [1:0] PIPE_NOP    = 2'd2;

    typedef enum logic [1:0] {
        FETCH         = 2'd0,
        REDIRECT_WAIT = 2'd1,
        HALTED        = 2'd2
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] pend_r;
    logic [31:0] d_instr_r;
    logic [31:0] d_pcplus4_r;
    logic        d_valid_r;

    logic [31:0] pcplus4_s;
    logic [31:0] tgt_raw_s;
    logic [31:0] tgt_s;
    logic        redirect_s;
    logic [31:0] fd_instr_s;
    logic [31:0] fd_pcplus4_s;
    logic        fd_valid_s;

    // Next-PC select; targets are word-aligned by dropping the low bits.
    always_comb begin
        pcplus4_s  = pc_r + 32'd4;
        redirect_s = (fif.PCSrc != 2'd0);
        case (fif.PCSrc)
            2'd0:    tgt_raw_s = pcplus4_s;
            2'd1:    tgt_raw_s = fif.branch_target;
            2'd2:    tgt_raw_s = fif.jump_target;
            2'd3:    tgt_raw_s = fif.jr_target;
            default: tgt_raw_s = pcplus4_s;
        endcase
        tgt_s = {tgt_raw_s[31:2], 2'b00};
    end

    // Normal fetch/decode latch update; unknown encodings hold like a stall.
    always_comb begin
        fd_instr_s   = d_instr_r;
        fd_pcplus4_s = d_pcplus4_r;
        fd_valid_s   = d_valid_r;
        case (fif.fd_state)
            PIPE_ENABLE: begin
                fd_instr_s   = fif.imemload;
                fd_pcplus4_s = pcplus4_s;
                fd_valid_s   = 1'b1;
            end
            PIPE_NOP: begin
                fd_instr_s   = 32'd0;
                fd_pcplus4_s = 32'd0;
                fd_valid_s   = 1'b0;
            end
            default: begin
                fd_instr_s   = d_instr_r;
                fd_pcplus4_s = d_pcplus4_r;
                fd_valid_s   = d_valid_r;
            end
        endcase
    end

    // Fetch FSM together with PC, pending redirect and the decode latch.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r     <= FETCH;
            pc_r        <= PC_INIT;
            pend_r      <= 32'd0;
            d_instr_r   <= 32'd0;
            d_pcplus4_r <= 32'd0;
            d_valid_r   <= 1'b0;
        end else begin
            case (state_r)
                FETCH: begin
                    d_instr_r   <= fd_instr_s;
                    d_pcplus4_r <= fd_pcplus4_s;
                    d_valid_r   <= fd_valid_s;
                    // A HALT with a redirect resolving is wrong-path and ignored.
                    if (fif.halt_in && d_valid_r && !redirect_s) begin
                        state_r <= HALTED;
                    end else if (fif.PC_WEN) begin
                        pc_r <= tgt_s;
                    end else if (redirect_s) begin
                        pend_r  <= tgt_s;
                        state_r <= REDIRECT_WAIT;
                    end else begin
                        pc_r <= pc_r;
                    end
                end
                REDIRECT_WAIT: begin
                    if (fif.PC_WEN) begin
                        pc_r        <= pend_r;
                        d_instr_r   <= 32'd0;
                        d_pcplus4_r <= 32'd0;
                        d_valid_r   <= 1'b0;
                        state_r     <= FETCH;
                    end else begin
                        d_instr_r   <= fd_instr_s;
                        d_pcplus4_r <= fd_pcplus4_s;
                        d_valid_r   <= fd_valid_s;
                        if (redirect_s) begin
                            pend_r <= tgt_s;
                        end else begin
                            pend_r <= pend_r;
                        end
                    end
                end
                HALTED: begin
                    state_r <= HALTED;
                end
                default: begin
                    state_r <= FETCH;
                end
            endcase
        end
    end

    assign fif.imemaddr     = pc_r;
    assign fif.imemREN      = (state_r != HALTED);
    assign fif.fetch_halted = (state_r == HALTED);
    assign fif.d_instr      = d_instr_r;
    assign fif.d_pcplus4    = d_pcplus4_r;
    assign fif.d_valid      = d_valid_r;
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// stimulus compared against a cycle-level reference model.
module tb_fetch_stage;
    logic CLK;
    logic nRST;
    int   total;
    int   bad;

    fetch_stage_if fif ();

    fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .fif  (fif)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model state
    logic [31:0] m_pc, m_pend, m_instr, m_pc4;
    logic        m_has_pend, m_halted, m_valid;

    task automatic model_reset();
        m_pc = 32'd0; m_pend = 32'd0; m_has_pend = 1'b0; m_halted = 1'b0;
        m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
    endtask

    // One clock of the fetch stage described in terms of its rules.
    task automatic model_step();
        logic [31:0] cand [4];
        logic [31:0] tgt;
        logic        redirect, old_valid;
        cand[0] = m_pc + 32'd4;
        cand[1] = fif.branch_target;
        cand[2] = fif.jump_target;
        cand[3] = fif.jr_target;
        tgt = cand[fif.PCSrc] & 32'hFFFF_FFFC;
        redirect = (fif.PCSrc != 2'd0);
        old_valid = m_valid;
        if (m_halted) return;
        if (m_has_pend && fif.PC_WEN) begin
            m_pc = m_pend; m_has_pend = 1'b0;
            m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
            return;
        end
        if (fif.fd_state == 2'd0) begin
            m_instr = fif.imemload; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
        end else if (fif.fd_state == 2'd2) begin
            m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
        end
        if (m_has_pend) begin
            if (redirect) m_pend = tgt;
        end else if (fif.halt_in && old_valid && !redirect) begin
            m_halted = 1'b1;
        end else if (fif.PC_WEN) begin
            m_pc = tgt;
        end else if (redirect) begin
            m_pend = tgt; m_has_pend = 1'b1;
        end
    endtask

    task automatic drive(input logic wen, input logic [1:0] fd, input logic [1:0] src,
                         input logic halt, input logic [31:0] load);
        fif.PC_WEN = wen; fif.fd_state = fd; fif.PCSrc = src;
        fif.halt_in = halt; fif.imemload = load; fif.ihit = 1'b1;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        #2;
        nRST = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        drive(1'b0, 2'd1, 2'd0, 1'b0, 32'd0);
        fif.branch_target = 32'd0; fif.jump_target = 32'd0; fif.jr_target = 32'd0;
        nRST = 1'b0;
        step();
        total++;
        if (fif.imemaddr !== 32'd0 || fif.imemREN !== 1'b1 || fif.fetch_halted !== 1'b0) begin
            bad++;
            $display("FAIL reset_pc: addr=%h ren=%b halted=%b want 0/1/0", fif.imemaddr, fif.imemREN, fif.fetch_halted);
        end
        total++;
        if (fif.d_instr !== 32'd0 || fif.d_pcplus4 !== 32'd0 || fif.d_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_latch: instr=%h pc4=%h valid=%b want 0/0/0", fif.d_instr, fif.d_pcplus4, fif.d_valid);
        end
        nRST = 1'b1;
    endtask

    task automatic test_sequential();
        logic [31:0] word;
        for (int i = 1; i <= 3; i++) begin
            word = $urandom;
            drive(1'b1, 2'd0, 2'd0, 1'b0, word);
            step();
            total++;
            if (fif.imemaddr !== 32'(4 * i) || fif.d_pcplus4 !== 32'(4 * i) ||
                fif.d_valid !== 1'b1 || fif.d_instr !== word) begin
                bad++;
                $display("FAIL seq_%0d: addr=%h pc4=%h valid=%b instr=%h want %h/%h/1/%h",
                         i, fif.imemaddr, fif.d_pcplus4, fif.d_valid, fif.d_instr, 4 * i, 4 * i, word);
            end
        end
    endtask

    task automatic test_branch_nop();
        fif.branch_target = 32'h0000_0103;
        drive(1'b1, 2'd2, 2'd1, 1'b0, 32'hDEAD_BEEF);
        step();
        total++;
        if (fif.imemaddr !== 32'h0000_0100 || fif.d_valid !== 1'b0) begin
            bad++;
            $display("FAIL branch_nop: addr=%h valid=%b want 00000100/0", fif.imemaddr, fif.d_valid);
        end
    endtask

    task automatic test_redirect_wait();
        fif.jump_target = 32'h0000_0040;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'd0, 2'd2, 1'b0, 32'h1111_0000 + 32'(i));
            step();
            total++;
            if (fif.imemaddr !== 32'h0000_0100) begin
                bad++;
                $display("FAIL redirect_hold_%0d: addr=%h want 00000100", i, fif.imemaddr);
            end
        end
        drive(1'b1, 2'd0, 2'd0, 1'b0, 32'h2222_2222);
        step();
        total++;
        if (fif.imemaddr !== 32'h0000_0040 || fif.d_valid !== 1'b0 || fif.d_instr !== 32'd0) begin
            bad++;
            $display("FAIL redirect_apply: addr=%h valid=%b instr=%h want 00000040/0/0", fif.imemaddr, fif.d_valid, fif.d_instr);
        end
        drive(1'b1, 2'd0, 2'd0, 1'b0, 32'h3333_3333);
        step();
        total++;
        if (fif.imemaddr !== 32'h0000_0044 || fif.d_valid !== 1'b1 || fif.d_pcplus4 !== 32'h0000_0044) begin
            bad++;
            $display("FAIL redirect_resume: addr=%h valid=%b pc4=%h want 00000044/1/00000044", fif.imemaddr, fif.d_valid, fif.d_pcplus4);
        end
    endtask

    task automatic test_wrap();
        fif.jr_target = 32'hFFFF_FFFF;
        drive(1'b1, 2'd0, 2'd3, 1'b0, 32'h4444_4444);
        step();
        total++;
        if (fif.imemaddr !== 32'hFFFF_FFFC) begin
            bad++;
            $display("FAIL wrap_align: addr=%h want fffffffc", fif.imemaddr);
        end
        drive(1'b1, 2'd0, 2'd0, 1'b0, 32'h5555_5555);
        step();
        total++;
        if (fif.imemaddr !== 32'd0 || fif.d_pcplus4 !== 32'd0 || fif.d_valid !== 1'b1) begin
            bad++;
            $display("FAIL wrap_pc: addr=%h pc4=%h valid=%b want 0/0/1", fif.imemaddr, fif.d_pcplus4, fif.d_valid);
        end
    endtask

    task automatic test_halt();
        drive(1'b1, 2'd1, 2'd0, 1'b1, 32'h6666_6666);
        step();
        total++;
        if (fif.imemREN !== 1'b0 || fif.fetch_halted !== 1'b1 || fif.imemaddr !== 32'd0) begin
            bad++;
            $display("FAIL halt_enter: ren=%b halted=%b addr=%h want 0/1/0", fif.imemREN, fif.fetch_halted, fif.imemaddr);
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b0, $urandom);
            step();
            total++;
            if (fif.imemaddr !== 32'd0 || fif.fetch_halted !== 1'b1 || fif.d_valid !== 1'b1 ||
                fif.d_instr !== 32'h5555_5555 || fif.d_pcplus4 !== 32'd0) begin
                bad++;
                $display("FAIL halt_frozen_%0d: addr=%h halted=%b valid=%b instr=%h pc4=%h want 0/1/1/55555555/0",
                         i, fif.imemaddr, fif.fetch_halted, fif.d_valid, fif.d_instr, fif.d_pcplus4);
            end
        end
        do_reset();
        drive(1'b1, 2'd0, 2'd0, 1'b0, 32'h7777_7777);
        step();
        fif.jr_target = 32'h0000_1234;
        drive(1'b1, 2'd0, 2'd3, 1'b1, 32'h8888_8888);
        step();
        total++;
        if (fif.fetch_halted !== 1'b0 || fif.imemREN !== 1'b1 || fif.imemaddr !== 32'h0000_1234) begin
            bad++;
            $display("FAIL halt_wrongpath: halted=%b ren=%b addr=%h want 0/1/00001234", fif.fetch_halted, fif.imemREN, fif.imemaddr);
        end
    endtask

    task automatic test_reset_mid_redirect();
        fif.branch_target = 32'h0000_0800;
        drive(1'b0, 2'd1, 2'd1, 1'b0, 32'd0);
        step();
        total++;
        if (fif.imemaddr !== 32'h0000_1234) begin
            bad++;
            $display("FAIL rst_redirect_wait: addr=%h want 00001234", fif.imemaddr);
        end
        nRST = 1'b0;
        #1;
        total++;
        if (fif.imemaddr !== 32'd0) begin
            bad++;
            $display("FAIL rst_async: addr=%h want 0", fif.imemaddr);
        end
        #1;
        nRST = 1'b1;
        drive(1'b1, 2'd0, 2'd0, 1'b0, 32'h9999_9999);
        step();
        total++;
        if (fif.imemaddr !== 32'h0000_0004) begin
            bad++;
            $display("FAIL rst_pend_discard: addr=%h want 00000004", fif.imemaddr);
        end
    endtask

    task automatic test_random();
        for (int round = 0; round < 6; round++) begin
            do_reset();
            for (int cyc = 0; cyc < 120; cyc++) begin
                fif.branch_target = $urandom;
                fif.jump_target   = $urandom;
                fif.jr_target     = $urandom;
                drive(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
                      2'($urandom_range(0, 3)),
                      ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(1, 3)),
                      ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
                      $urandom);
                model_step();
                step();
                total++;
                if (fif.imemaddr !== m_pc || fif.imemREN !== !m_halted || fif.fetch_halted !== m_halted) begin
                    bad++;
                    $display("FAIL rand_pc r%0d c%0d: addr=%h ren=%b halted=%b want %h/%b/%b",
                             round, cyc, fif.imemaddr, fif.imemREN, fif.fetch_halted, m_pc, !m_halted, m_halted);
                end
                total++;
                if (fif.d_instr !== m_instr || fif.d_pcplus4 !== m_pc4 || fif.d_valid !== m_valid) begin
                    bad++;
                    $display("FAIL rand_latch r%0d c%0d: instr=%h pc4=%h valid=%b want %h/%h/%b",
                             round, cyc, fif.d_instr, fif.d_pcplus4, fif.d_valid, m_instr, m_pc4, m_valid);
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        nRST = 1'b1;
        #1;
        test_reset();
        test_sequential();
        test_branch_nop();
        test_redirect_wait();
        test_wrap();
        test_halt();
        test_reset_mid_redirect();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
